// File: rtl/csa_tree_pipe.sv
// ---------------------------------------------------------------------------
// csa_tree_pipe
//   Fully pipelined carry-save (3:2 compressor) adder tree summing DATA_N
//   operands of DATA_W bits (signed or unsigned), with a per-lane mask and a
//   valid/ready stream handshake. The whole pipe advances together; it stalls
//   only when the output holds a result that downstream has not taken.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_valid  in   operand vector valid
//   o_ready  out  block can accept a vector this cycle
//   i_data   in   packed operands, lane k is i_data[k]
//   i_mask   in   bit k = 1 includes lane k, 0 forces it to zero
//   o_valid  out  result valid
//   i_ready  in   downstream accepts the result
//   o_data   out  sum of unmasked lanes, O_DATA_W bits (exact)
// ---------------------------------------------------------------------------
module csa_tree_pipe #(
    parameter  int DATA_W   = 8,
    parameter  int DATA_N   = 9,
    parameter  int SIGNED   = 0,
    localparam int O_DATA_W = DATA_W + ((DATA_N > 1) ? $clog2(DATA_N) : 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [0:DATA_N-1][DATA_W-1:0]    i_data,
    input  logic [DATA_N-1:0]                i_mask,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [O_DATA_W-1:0]              o_data
);

    // Rows remaining after a given number of 3:2 levels.
    function automatic int rows_after(input int n_in, input int unsigned levels);
        int n;
        n = n_in;
        for (int unsigned i = 0; i < levels; i++) begin
            if (n > 2) n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int num_stages(input int n_in);
        int n;
        int cnt;
        n   = n_in;
        cnt = 0;
        while (n > 2) begin
            n   = 2 * (n / 3) + n % 3;
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    // Row index of level lvl's first register inside the flat stage vector
    // (level 1 starts at row 0).
    function automatic int row_offset(input int n_in, input int unsigned lvl);
        int total;
        total = 0;
        for (int unsigned k = 1; k < lvl; k++) total += rows_after(n_in, k);
        return total;
    endfunction

    localparam int STAGES_N = num_stages(DATA_N);
    localparam int LATENCY  = STAGES_N + 1;

    logic                     adv_w;
    logic [LATENCY-1:0]       vld_q, vld_d;
    logic [O_DATA_W-1:0]      sum_q;
    logic [O_DATA_W-1:0]      row0_w, row1_w;
    logic [DATA_N-1:0][O_DATA_W-1:0] lane_w;

    // Advance depends only on the output stage, so bubbles flow rather than compress.
    assign adv_w   = ~vld_q[LATENCY-1] | i_ready;
    assign o_ready = adv_w;
    assign o_valid = vld_q[LATENCY-1];
    assign o_data  = sum_q;

    // Stage 0: extend each lane, then zero it if masked or if no vector is offered.
    for (genvar k = 0; k < DATA_N; k++) begin : g_lane
        logic [O_DATA_W-1:0] ext_w;
        if (SIGNED != 0) begin : g_sx
            assign ext_w = {{(O_DATA_W-DATA_W){i_data[k][DATA_W-1]}}, i_data[k]};
        end else begin : g_zx
            assign ext_w = {{(O_DATA_W-DATA_W){1'b0}}, i_data[k]};
        end
        assign lane_w[k] = ext_w & {O_DATA_W{i_mask[k] & i_valid}};
    end

    if (STAGES_N == 0) begin : g_no_tree
        assign row0_w = lane_w[0];
        if (DATA_N == 2) begin : g_two
            assign row1_w = lane_w[1];
        end else begin : g_one
            assign row1_w = '0;
        end
    end else begin : g_tree
        // Levels shrink in row count, so all level registers are exposed through
        // one flat vector with per-level offsets instead of a ragged array.
        localparam int TOT_ROWS = row_offset(DATA_N, STAGES_N + 1);
        localparam int LAST_OFF = row_offset(DATA_N, STAGES_N);
        logic [TOT_ROWS*O_DATA_W-1:0] stg_w;

        for (genvar lv = 1; lv <= STAGES_N; lv++) begin : g_lvl
            localparam int N_IN    = rows_after(DATA_N, lv - 1);
            localparam int N_OUT   = rows_after(DATA_N, lv);
            localparam int N_TRI   = N_IN / 3;
            localparam int N_LEFT  = N_IN % 3;
            localparam int OUT_OFF = row_offset(DATA_N, lv);

            logic [N_IN-1:0][O_DATA_W-1:0]  in_w;
            logic [N_OUT-1:0][O_DATA_W-1:0] rows_d, rows_q;

            if (lv == 1) begin : g_first
                assign in_w = lane_w;
            end else begin : g_next
                assign in_w = stg_w[row_offset(DATA_N, lv - 1)*O_DATA_W +: N_IN*O_DATA_W];
            end

            always_comb begin
                rows_d = '0;
                for (int unsigned t = 0; t < N_TRI; t++) begin
                    rows_d[2*t]   = in_w[3*t] ^ in_w[3*t+1] ^ in_w[3*t+2];
                    rows_d[2*t+1] = ((in_w[3*t]   & in_w[3*t+1]) |
                                     (in_w[3*t]   & in_w[3*t+2]) |
                                     (in_w[3*t+1] & in_w[3*t+2])) << 1;
                end
                for (int unsigned j = 0; j < N_LEFT; j++) begin
                    rows_d[2*N_TRI+j] = in_w[3*N_TRI+j];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rows_q <= '0;
                end else if (adv_w) begin
                    rows_q <= rows_d;
                end
            end

            assign stg_w[OUT_OFF*O_DATA_W +: N_OUT*O_DATA_W] = rows_q;
        end

        assign row0_w = stg_w[LAST_OFF*O_DATA_W +: O_DATA_W];
        assign row1_w = stg_w[(LAST_OFF+1)*O_DATA_W +: O_DATA_W];
    end

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = i_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sum_q <= '0;
        end else if (adv_w) begin
            vld_q <= vld_d;
            sum_q <= row0_w + row1_w;
        end
    end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_csa_tree_pipe
//   Self-checking bench for csa_tree_pipe. Instantiates the default unsigned
//   configuration, a signed one, and the small corner configurations, and
//   compares against operand sums computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_csa_tree_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // main: DATA_N=9, DATA_W=8, unsigned
    logic             m_valid = 1'b0, m_oready, m_ovalid, m_iready = 1'b0;
    logic [0:8][7:0]  m_data  = '0;
    logic [8:0]       m_mask  = '0;
    logic [11:0]      m_odata;
    // signed: DATA_N=9, DATA_W=8, SIGNED=1
    logic             s_valid = 1'b0, s_oready, s_ovalid;
    logic [0:8][7:0]  s_data  = '0;
    logic [8:0]       s_mask  = '0;
    logic [11:0]      s_odata;
    // corner configurations, downstream always ready
    logic             aux_ready = 1'b1;
    logic             c_valid   = 1'b0;
    logic             c1_oready, c1_ovalid, c2_oready, c2_ovalid;
    logic             c3_oready, c3_ovalid, c16_oready, c16_ovalid;
    logic [0:0][7:0]  c1_data  = '0;
    logic [0:0]       c1_mask  = '0;
    logic [8:0]       c1_odata;
    logic [0:1][7:0]  c2_data  = '0;
    logic [1:0]       c2_mask  = '0;
    logic [8:0]       c2_odata;
    logic [0:2][7:0]  c3_data  = '0;
    logic [2:0]       c3_mask  = '0;
    logic [9:0]       c3_odata;
    logic [0:15][0:0] c16_data = '0;
    logic [15:0]      c16_mask = '0;
    logic [4:0]       c16_odata;

    csa_tree_pipe #(.DATA_W(8), .DATA_N(9), .SIGNED(0)) u_main (
        .clk(clk), .rst_n(rst_n), .i_valid(m_valid), .o_ready(m_oready),
        .i_data(m_data), .i_mask(m_mask), .o_valid(m_ovalid),
        .i_ready(m_iready), .o_data(m_odata));
    csa_tree_pipe #(.DATA_W(8), .DATA_N(9), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .i_valid(s_valid), .o_ready(s_oready),
        .i_data(s_data), .i_mask(s_mask), .o_valid(s_ovalid),
        .i_ready(aux_ready), .o_data(s_odata));
    csa_tree_pipe #(.DATA_W(8), .DATA_N(1), .SIGNED(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .i_valid(c_valid), .o_ready(c1_oready),
        .i_data(c1_data), .i_mask(c1_mask), .o_valid(c1_ovalid),
        .i_ready(aux_ready), .o_data(c1_odata));
    csa_tree_pipe #(.DATA_W(8), .DATA_N(2), .SIGNED(0)) u_c2 (
        .clk(clk), .rst_n(rst_n), .i_valid(c_valid), .o_ready(c2_oready),
        .i_data(c2_data), .i_mask(c2_mask), .o_valid(c2_ovalid),
        .i_ready(aux_ready), .o_data(c2_odata));
    csa_tree_pipe #(.DATA_W(8), .DATA_N(3), .SIGNED(0)) u_c3 (
        .clk(clk), .rst_n(rst_n), .i_valid(c_valid), .o_ready(c3_oready),
        .i_data(c3_data), .i_mask(c3_mask), .o_valid(c3_ovalid),
        .i_ready(aux_ready), .o_data(c3_odata));
    csa_tree_pipe #(.DATA_W(1), .DATA_N(16), .SIGNED(0)) u_c16 (
        .clk(clk), .rst_n(rst_n), .i_valid(c_valid), .o_ready(c16_oready),
        .i_data(c16_data), .i_mask(c16_mask), .o_valid(c16_ovalid),
        .i_ready(aux_ready), .o_data(c16_odata));

    // Reference: arithmetic sum of included lanes.
    function automatic int ref9(input logic [0:8][7:0] d, input logic [8:0] m, input bit sgn);
        int s = 0;
        for (int k = 0; k < 9; k++)
            if (m[k]) s += sgn ? int'($signed(d[k])) : int'(d[k]);
        return s;
    endfunction

    // Sends one vector to the idle main pipe and records when/what comes out.
    task automatic main_one(input logic [0:8][7:0] d, input logic [8:0] m,
                            output int lat, output int nv, output logic [11:0] q);
        @(negedge clk);
        m_iready = 1'b1; m_valid = 1'b1; m_data = d; m_mask = m;
        lat = -1; nv = 0; q = '0;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (c == 1) m_valid = 1'b0;
            if (m_ovalid) begin
                nv++;
                if (lat < 0) begin lat = c; q = m_odata; end
            end
            @(posedge clk);
        end
    endtask

    task automatic sgn_one(input logic [0:8][7:0] d, input logic [8:0] m,
                           output int lat, output int nv, output logic [11:0] q);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_mask = m;
        lat = -1; nv = 0; q = '0;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (c == 1) s_valid = 1'b0;
            if (s_ovalid) begin
                nv++;
                if (lat < 0) begin lat = c; q = s_odata; end
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #10;
        n_checks++; if (m_ovalid !== 1'b0) $display("FAIL reset_ovalid got=%b want=0", m_ovalid); else n_pass++;
        n_checks++; if (m_odata !== 12'h000) $display("FAIL reset_odata got=%h want=000", m_odata); else n_pass++;
        n_checks++; if (m_oready !== 1'b1) $display("FAIL reset_oready got=%b want=1", m_oready); else n_pass++;
        n_checks++; if (c16_ovalid !== 1'b0) $display("FAIL reset_c16_ovalid got=%b want=0", c16_ovalid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [0:8][7:0] d;
        logic [8:0]      m;
        logic [11:0]     q;
        int lat, nv, exp;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                for (int k = 0; k < 9; k++) d[k] = 8'hFF;
                m = '1;
            end else begin
                for (int k = 0; k < 9; k++) d[k] = 8'($urandom);
                m = '1;
            end
            exp = (i == 0) ? 2295 : ref9(d, m, 1'b0);
            main_one(d, m, lat, nv, q);
            n_checks++; if (lat !== 5) $display("FAIL unsigned_latency[%0d] got=%0d want=5", i, lat); else n_pass++;
            n_checks++; if (nv !== 1) $display("FAIL unsigned_count[%0d] got=%0d want=1", i, nv); else n_pass++;
            n_checks++; if (q !== 12'(exp)) $display("FAIL unsigned_sum[%0d] got=%h want=%h", i, q, 12'(exp)); else n_pass++;
        end
    endtask

    task automatic test_mask();
        logic [0:8][7:0] d;
        logic [8:0]      m;
        logic [11:0]     q;
        int lat, nv, exp;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 9; k++) d[k] = 8'(k + 1);
            case (i)
                0: begin m = 9'b000000101; exp = 4; end
                1: begin m = 9'b000000000; exp = 0; end
                default: begin
                    for (int k = 0; k < 9; k++) d[k] = 8'($urandom);
                    m = 9'($urandom);
                    exp = ref9(d, m, 1'b0);
                end
            endcase
            main_one(d, m, lat, nv, q);
            n_checks++; if (lat !== 5) $display("FAIL mask_latency[%0d] got=%0d want=5", i, lat); else n_pass++;
            n_checks++; if (q !== 12'(exp)) $display("FAIL mask_sum[%0d] got=%h want=%h", i, q, 12'(exp)); else n_pass++;
        end
    endtask

    task automatic test_signed();
        logic [0:8][7:0] d;
        logic [8:0]      m;
        logic [11:0]     q;
        int lat, nv, exp;
        for (int i = 0; i < 5; i++) begin
            m = '1;
            case (i)
                0: begin for (int k = 0; k < 9; k++) d[k] = 8'h80; exp = -1152; end
                1: begin
                    for (int k = 0; k < 9; k++) d[k] = (k % 2 == 0) ? 8'h01 : 8'hFF;
                    d[8] = 8'h05;
                    exp = 5;
                end
                default: begin
                    for (int k = 0; k < 9; k++) d[k] = 8'($urandom);
                    m = 9'($urandom);
                    exp = ref9(d, m, 1'b1);
                end
            endcase
            sgn_one(d, m, lat, nv, q);
            n_checks++; if (lat !== 5) $display("FAIL signed_latency[%0d] got=%0d want=5", i, lat); else n_pass++;
            n_checks++; if (nv !== 1) $display("FAIL signed_count[%0d] got=%0d want=1", i, nv); else n_pass++;
            n_checks++; if (q !== 12'(exp)) $display("FAIL signed_sum[%0d] got=%h want=%h", i, q, 12'(exp)); else n_pass++;
        end
    endtask

    task automatic test_corners();
        for (int it = 0; it < 4; it++) begin
            int e1, e2, e3, e16;
            int l1, l2, l3, l16, v1, v2, v3, v16;
            logic [8:0] q1, q2;
            logic [9:0] q3;
            logic [4:0] q16;
            @(negedge clk);
            if (it == 0) begin
                c1_data[0] = 8'h80; c1_mask = '1;
                c2_data[0] = 8'hFF; c2_data[1] = 8'hFF; c2_mask = '1;
                for (int k = 0; k < 3; k++) c3_data[k] = 8'hFF;
                c3_mask = '1;
                c16_data = '1; c16_mask = '1;
            end else begin
                c1_data[0] = 8'($urandom); c1_mask = 1'($urandom);
                for (int k = 0; k < 2; k++) c2_data[k] = 8'($urandom);
                c2_mask = 2'($urandom);
                for (int k = 0; k < 3; k++) c3_data[k] = 8'($urandom);
                c3_mask = 3'($urandom);
                c16_data = 16'($urandom); c16_mask = 16'($urandom);
            end
            e1 = c1_mask[0] ? int'($signed(c1_data[0])) : 0;
            e2 = 0; for (int k = 0; k < 2; k++) if (c2_mask[k]) e2 += int'(c2_data[k]);
            e3 = 0; for (int k = 0; k < 3; k++) if (c3_mask[k]) e3 += int'(c3_data[k]);
            e16 = 0; for (int k = 0; k < 16; k++) if (c16_mask[k] && c16_data[k][0]) e16++;
            c_valid = 1'b1;
            l1 = -1; l2 = -1; l3 = -1; l16 = -1; v1 = 0; v2 = 0; v3 = 0; v16 = 0;
            q1 = '0; q2 = '0; q3 = '0; q16 = '0;
            @(posedge clk);
            for (int c = 1; c <= 10; c++) begin
                #1;
                if (c == 1) c_valid = 1'b0;
                if (c1_ovalid)  begin v1++;  if (l1 < 0)  begin l1 = c;  q1 = c1_odata;   end end
                if (c2_ovalid)  begin v2++;  if (l2 < 0)  begin l2 = c;  q2 = c2_odata;   end end
                if (c3_ovalid)  begin v3++;  if (l3 < 0)  begin l3 = c;  q3 = c3_odata;   end end
                if (c16_ovalid) begin v16++; if (l16 < 0) begin l16 = c; q16 = c16_odata; end end
                @(posedge clk);
            end
            n_checks++; if (l1 !== 1 || v1 !== 1) $display("FAIL n1_timing[%0d] got lat=%0d cnt=%0d want lat=1 cnt=1", it, l1, v1); else n_pass++;
            n_checks++; if (q1 !== 9'(e1)) $display("FAIL n1_sum[%0d] got=%h want=%h", it, q1, 9'(e1)); else n_pass++;
            n_checks++; if (l2 !== 1 || v2 !== 1) $display("FAIL n2_timing[%0d] got lat=%0d cnt=%0d want lat=1 cnt=1", it, l2, v2); else n_pass++;
            n_checks++; if (q2 !== 9'(e2)) $display("FAIL n2_sum[%0d] got=%h want=%h", it, q2, 9'(e2)); else n_pass++;
            n_checks++; if (l3 !== 2 || v3 !== 1) $display("FAIL n3_timing[%0d] got lat=%0d cnt=%0d want lat=2 cnt=1", it, l3, v3); else n_pass++;
            n_checks++; if (q3 !== 10'(e3)) $display("FAIL n3_sum[%0d] got=%h want=%h", it, q3, 10'(e3)); else n_pass++;
            n_checks++; if (l16 !== 7 || v16 !== 1) $display("FAIL n16_timing[%0d] got lat=%0d cnt=%0d want lat=7 cnt=1", it, l16, v16); else n_pass++;
            n_checks++; if (q16 !== 5'(e16)) $display("FAIL n16_popcount[%0d] got=%0d want=%0d", it, q16, e16); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp [8];
        m_iready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc < 8) begin
                m_valid = 1'b1;
                for (int k = 0; k < 9; k++) m_data[k] = 8'($urandom);
                m_mask = 9'($urandom);
                exp[cyc] = 12'(ref9(m_data, m_mask, 1'b0));
            end else begin
                m_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (m_ovalid !== (cyc >= 5 && cyc < 13)) $display("FAIL b2b_valid[%0d] got=%b want=%b", cyc, m_ovalid, (cyc >= 5 && cyc < 13));
            else n_pass++;
            if (cyc >= 5 && cyc < 13) begin
                n_checks++;
                if (m_odata !== exp[cyc-5]) $display("FAIL b2b_sum[%0d] got=%h want=%h", cyc, m_odata, exp[cyc-5]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stream();
        logic [11:0] expq[$];
        logic [11:0] held_d = '0;
        logic [11:0] want;
        logic        held_v = 1'b0;
        int sent = 0, got = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 400 && (sent < 20 || expq.size() != 0); cyc++) begin
            m_iready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                m_valid = 1'b1;
                for (int k = 0; k < 9; k++) m_data[k] = 8'($urandom);
                m_mask = 9'($urandom);
            end else begin
                m_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (m_oready !== (~m_ovalid | m_iready)) $display("FAIL stream_oready[%0d] got=%b want=%b", cyc, m_oready, ~m_ovalid | m_iready);
            else n_pass++;
            if (held_v) begin
                n_checks++;
                if (m_ovalid !== 1'b1 || m_odata !== held_d)
                    $display("FAIL stream_hold[%0d] got v=%b d=%h want v=1 d=%h", cyc, m_ovalid, m_odata, held_d);
                else n_pass++;
            end
            if (m_ovalid && m_iready) begin
                n_checks++;
                if (expq.size() == 0) begin
                    $display("FAIL stream_spurious[%0d] got=%h want=no result", cyc, m_odata);
                end else begin
                    want = expq.pop_front();
                    if (m_odata !== want) $display("FAIL stream_sum[%0d] got=%h want=%h", got, m_odata, want);
                    else n_pass++;
                end
                got++;
            end
            held_v = m_ovalid && !m_iready;
            held_d = m_odata;
            if (m_valid && m_oready) begin
                expq.push_back(12'(ref9(m_data, m_mask, 1'b0)));
                sent++;
            end
            @(negedge clk);
        end
        m_valid = 1'b0; m_iready = 1'b1;
        n_checks++;
        if (sent !== 20 || got !== 20 || expq.size() !== 0)
            $display("FAIL stream_totals got sent=%0d out=%0d left=%0d want 20/20/0", sent, got, expq.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        m_iready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            m_valid = 1'b1;
            for (int k = 0; k < 9; k++) m_data[k] = 8'($urandom);
            m_mask = '1;
        end
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        n_checks++; if (m_ovalid !== 1'b1) $display("FAIL midrst_pre_valid got=%b want=1", m_ovalid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_ovalid !== 1'b0) $display("FAIL midrst_ovalid got=%b want=0", m_ovalid); else n_pass++;
        n_checks++; if (m_odata !== 12'h000) $display("FAIL midrst_odata got=%h want=000", m_odata); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (m_ovalid !== 1'b0 || m_odata !== 12'h000)
                $display("FAIL midrst_quiet[%0d] got v=%b d=%h want v=0 d=000", c, m_ovalid, m_odata);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_mask();
        test_signed();
        test_corners();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
